line_draw_ctrl: RTL and testbench

- Sequencing controller for the Bresenham line datapath.
- Accepts polyline commands: pen-move, or draw from the current pen point to a new endpoint.
- Drives the datapath 5-bit state code, the endpoint bus and the old-point register enables.
- Presents each computed pixel to the frame-buffer writer on a valid/ready plot handshake, freezing the datapath under backpressure.

---
 rtl/line_draw_ctrl_pkg.sv | 18 +
 rtl/line_draw_ctrl_if.sv | 44 ++++
 rtl/line_draw_fsm.sv | 53 +++++
 rtl/line_draw_ctrl.sv | 87 ++++++++
 tb/tb_line_draw_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_draw_ctrl_pkg.sv
// Shared state codes and default widths for the Bresenham line-draw sequencing controller.
package line_draw_ctrl_pkg;

  localparam int W_DEF  = 9;
  localparam int SW_DEF = 5;

  // Codes are driven straight onto the datapath state bus; ST_STALL is never held in the FSM.
  typedef enum logic [SW_DEF-1:0] {
    ST_IDLE   = 5'd1,
    ST_SETUP  = 5'd2,
    ST_SETUP2 = 5'd3,
    ST_SETUP3 = 5'd4,
    ST_DRAW   = 5'd5,
    ST_DONE   = 5'd6,
    ST_STALL  = 5'd7
  } state_e;

endpackage

// File: rtl/line_draw_ctrl_if.sv
// Command, datapath and plot-handshake bundle between the line-draw controller and its neighbours.
interface line_draw_ctrl_if #(
  parameter int W  = 9,
  parameter int SW = 5
);

  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_move;
  logic [W-1:0] cmd_x;
  logic [W-1:0] cmd_y;

  logic [W-1:0]  new_X;
  logic [W-1:0]  new_Y;
  logic          old_X_enable;
  logic          old_Y_enable;
  logic [SW-1:0] state;
  logic          xlex1;
  logic [W-1:0]  x_Q;
  logic [W-1:0]  y_Q;

  logic         plot_valid;
  logic         plot_ready;
  logic [W-1:0] plot_x;
  logic [W-1:0] plot_y;

  logic busy;
  logic line_done;

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_move, cmd_x, cmd_y, xlex1, x_Q, y_Q, plot_ready,
    output cmd_ready, new_X, new_Y, old_X_enable, old_Y_enable, state,
           plot_valid, plot_x, plot_y, busy, line_done
  );

  // Command source, datapath and frame-buffer writer side.
  modport master (
    output cmd_valid, cmd_move, cmd_x, cmd_y, xlex1, x_Q, y_Q, plot_ready,
    input  cmd_ready, new_X, new_Y, old_X_enable, old_Y_enable, state,
           plot_valid, plot_x, plot_y, busy, line_done
  );

endinterface

// File: rtl/line_draw_fsm.sv
// Sequencing FSM for the line datapath: next-state logic and the stall override on the state bus.
module line_draw_fsm
  import line_draw_ctrl_pkg::*;
#(
  parameter int SW = SW_DEF
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          accept,
  input  logic          cmd_move,
  input  logic          xlex1,
  input  logic          stall,
  input  logic          kill,
  output state_e        fsm_q,
  output logic [SW-1:0] state_code
);

  state_e fsm_d;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fsm_q <= ST_IDLE;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    fsm_d      = fsm_q;
    state_code = SW'(fsm_q);

    case (fsm_q)
      ST_IDLE:   if (accept) fsm_d = cmd_move ? ST_DONE : ST_SETUP;
      ST_SETUP:  fsm_d = ST_SETUP2;
      ST_SETUP2: fsm_d = ST_SETUP3;
      ST_SETUP3: fsm_d = ST_DRAW;
      ST_DRAW:   if (!xlex1) fsm_d = ST_DONE;
      ST_DONE:   fsm_d = ST_IDLE;
      default:   fsm_d = ST_IDLE;
    endcase

    // Backpressure freezes both the FSM and the datapath, which ignores code 7.
    if (stall) begin
      fsm_d      = fsm_q;
      state_code = SW'(ST_STALL);
    end

    if (kill) fsm_d = ST_DONE;
  end

endmodule

// File: rtl/line_draw_ctrl.sv
// Line-draw sequencing controller: latches endpoints, steps the datapath, streams pixels out.
// Optional abort input enabled by defining LINE_DRAW_CTRL_ABORT_EN.
module line_draw_ctrl
  import line_draw_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic clock,
  input  logic resetN,
`ifdef LINE_DRAW_CTRL_ABORT_EN
  input  logic abort,
`endif
  line_draw_ctrl_if.slave ctl
);

  state_e       fsm_q;
  logic         accept;
  logic         stall;
  logic         kill;
  logic [W-1:0] new_x_q, new_x_d;
  logic [W-1:0] new_y_q, new_y_d;
  logic         plot_valid_q, plot_valid_d;

  assign ctl.cmd_ready = (fsm_q == ST_IDLE);
  assign accept        = ctl.cmd_valid && ctl.cmd_ready;
  assign stall         = plot_valid_q && !ctl.plot_ready;

`ifdef LINE_DRAW_CTRL_ABORT_EN
  // Abort only matters once a line is in flight; IDLE and DONE already end at the pen update.
  assign kill = abort && (fsm_q inside {ST_SETUP, ST_SETUP2, ST_SETUP3, ST_DRAW});
`else
  assign kill = 1'b0;
`endif

  line_draw_fsm #(.SW(SW)) u_fsm (
    .clock      (clock),
    .resetN     (resetN),
    .accept     (accept),
    .cmd_move   (ctl.cmd_move),
    .xlex1      (ctl.xlex1),
    .stall      (stall),
    .kill       (kill),
    .fsm_q      (fsm_q),
    .state_code (ctl.state)
  );

  always_comb begin
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    plot_valid_d = plot_valid_q;

    if (accept) begin
      new_x_d = ctl.cmd_x;
      new_y_d = ctl.cmd_y;
    end

    // The pixel on x_Q/y_Q becomes valid one edge after the DRAW cycle that produced it.
    if (kill)                   plot_valid_d = 1'b0;
    else if (stall)             plot_valid_d = plot_valid_q;
    else if (fsm_q == ST_DRAW)  plot_valid_d = ctl.xlex1;
    else if (ctl.plot_ready)    plot_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      new_x_q      <= '0;
      new_y_q      <= '0;
      plot_valid_q <= 1'b0;
    end else begin
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      plot_valid_q <= plot_valid_d;
    end
  end

  assign ctl.new_X        = new_x_q;
  assign ctl.new_Y        = new_y_q;
  assign ctl.old_X_enable = (fsm_q == ST_DONE);
  assign ctl.old_Y_enable = (fsm_q == ST_DONE);
  assign ctl.line_done    = (fsm_q == ST_DONE);
  assign ctl.busy         = (fsm_q != ST_IDLE);
  assign ctl.plot_valid   = plot_valid_q;
  assign ctl.plot_x       = ctl.x_Q;
  assign ctl.plot_y       = ctl.y_Q;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Bench for line_draw_ctrl: behavioural Bresenham datapath, scoreboard of expected pixels, directed lines.
`timescale 1ns/1ps
module tb_line_draw_ctrl;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  line_draw_ctrl_if #(.W(9), .SW(5)) bus ();

`ifdef LINE_DRAW_CTRL_ABORT_EN
  logic abort;
`endif

  line_draw_ctrl #(.W(9), .SW(5)) dut (
    .clock  (clock),
    .resetN (resetN),
`ifdef LINE_DRAW_CTRL_ABORT_EN
    .abort  (abort),
`endif
    .ctl    (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // ---------------- behavioural datapath ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int npix(input int x0, input int y0, input int x1, input int y1);
    int dx, dy;
    dx = iabs(x1 - x0);
    dy = iabs(y1 - y0);
    return ((dx > dy) ? dx : dy) + 1;
  endfunction

  function automatic logic [17:0] bres_pt(input int x0, input int y0, input int x1, input int y1, input int k);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = iabs(x1 - x0);
    dy  = iabs(y1 - y0);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx - dy;
    x   = x0;
    y   = y0;
    for (int i = 0; i < k; i++) begin
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
    return {x[8:0], y[8:0]};
  endfunction

  int pen_x = 0, pen_y = 0;
  int ax0 = 0, ay0 = 0, ax1 = 0, ay1 = 0;
  int dp_p = 0;

  always @(posedge clock) begin
    if (bus.old_X_enable) pen_x <= int'(bus.new_X);
    if (bus.old_Y_enable) pen_y <= int'(bus.new_Y);
    case (bus.state)
      5'd2: begin
        ax0 <= pen_x;
        ay0 <= pen_y;
        ax1 <= int'(bus.new_X);
        ay1 <= int'(bus.new_Y);
      end
      5'd4: dp_p <= 0;
      5'd5: begin
        {bus.x_Q, bus.y_Q} <= bres_pt(ax0, ay0, ax1, ay1, dp_p);
        dp_p <= dp_p + 1;
      end
      default: ;
    endcase
  end

  assign bus.xlex1 = (dp_p < npix(ax0, ay0, ax1, ay1));

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int xfers = 0;

  task automatic push(input int x, input int y);
    exp_q.push_back({9'(x), 9'(y)});
  endtask

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clock);
      if (resetN && bus.plot_valid && bus.plot_ready) begin
        xfers++;
        check($sformatf("sb_has_entry plot#%0d", xfers), int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("plot#%0d got(%0d,%0d) want(%0d,%0d)", xfers, bus.plot_x, bus.plot_y,
                          e[17:9], e[8:0]),
                int'({bus.plot_x, bus.plot_y}), int'(e));
        end
      end
    end
  end

  // ---------------- command runner ----------------
  task automatic run_cmd(input string nm, input logic mv, input int x, input int y,
                         input int exp_plots, input int exp_first,
                         input int stall_at, input int stall_len, input int abort_at);
    int c, xf, first, last, dn, dn_bad, rdy_bad, st_cyc, st7, hold_bad, stall_left;
    int c_abort, c_done;
    bit done, ab_done;
    logic [17:0] hold;
    c = 0; xf = 0; first = -1; last = -1; dn = 0; dn_bad = 0; rdy_bad = 0;
    st_cyc = 0; st7 = 0; hold_bad = 0; stall_left = stall_len;
    c_abort = -1; c_done = -1; done = 0; ab_done = 0; hold = '0;

    @(negedge clock);
    check({nm, "_cmd_ready_idle"}, int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_move  = mv;
    bus.cmd_x     = 9'(x);
    bus.cmd_y     = 9'(y);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;

    while (!done && c < 200) begin
      c++;
      bus.plot_ready = 1'b1;
      if (stall_left > 0 && xf == stall_at && bus.plot_valid) begin
        bus.plot_ready = 1'b0;
        stall_left--;
      end
`ifdef LINE_DRAW_CTRL_ABORT_EN
      abort = 1'b0;
      if (abort_at >= 0 && !ab_done && xf == abort_at) begin
        abort          = 1'b1;
        bus.plot_ready = 1'b0;
        ab_done        = 1'b1;
        c_abort        = c;
      end
`endif
      @(negedge clock);
      if (bus.plot_valid && bus.plot_ready) begin
        xf++;
        if (first < 0) first = c;
        last = c;
      end
      if (stall_at >= 0 && bus.plot_valid && !bus.plot_ready) begin
        st_cyc++;
        if (bus.state == 5'd7) st7++;
        if (st_cyc == 1) hold = {bus.plot_x, bus.plot_y};
        else if ({bus.plot_x, bus.plot_y} != hold) hold_bad++;
      end
      if (bus.line_done) begin
        dn++;
        c_done = c;
        if (!(bus.old_X_enable && bus.old_Y_enable && bus.new_X == 9'(x) && bus.new_Y == 9'(y)))
          dn_bad++;
      end
      if (bus.busy && bus.cmd_ready) rdy_bad++;
      if (!bus.busy) done = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
`ifdef LINE_DRAW_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    bus.plot_ready = 1'b1;

    check({nm, "_returned_idle"}, int'(done), 1);
    check({nm, "_plot_count"}, xf, exp_plots);
    check({nm, "_first_plot_cycle"}, first, exp_first);
    check({nm, "_line_done_pulses"}, dn, 1);
    check({nm, "_done_pen_load_bad"}, dn_bad, 0);
    check({nm, "_cmd_ready_while_busy"}, rdy_bad, 0);
    check({nm, "_sb_drained"}, int'(exp_q.size()), 0);
    if (stall_len > 0) begin
      check({nm, "_stall_code_cycles"}, st7, stall_len);
      check({nm, "_stall_pixel_moved"}, hold_bad, 0);
    end else if (abort_at < 0 && exp_plots > 0) begin
      check({nm, "_back_to_back"}, last - first, exp_plots - 1);
    end
`ifdef LINE_DRAW_CTRL_ABORT_EN
    if (abort_at >= 0) check({nm, "_abort_to_done"}, c_done - c_abort, 1);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    resetN         = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_move   = 1'b0;
    bus.cmd_x      = '0;
    bus.cmd_y      = '0;
    bus.plot_ready = 1'b1;
`ifdef LINE_DRAW_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("reset_state_code", int'(bus.state), 1);
    check("reset_plot_valid", int'(bus.plot_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_line_done", int'(bus.line_done), 0);
    check("reset_old_enables", int'({bus.old_X_enable, bus.old_Y_enable}), 0);
    check("reset_new_xy", int'({bus.new_X, bus.new_Y}), 0);
    check("reset_cmd_ready", int'(bus.cmd_ready), 1);
    resetN = 1'b1;

    for (int i = 0; i <= 3; i++) push(i, 0);
    run_cmd("line_0_0_to_3_0", 1'b0, 3, 0, 4, 5, -1, 0, -1);

    run_cmd("move_10_10", 1'b1, 10, 10, 0, -1, -1, 0, -1);
    push(10, 10); push(10, 11); push(11, 12); push(11, 13);
    push(11, 14); push(12, 15); push(12, 16);
    run_cmd("steep_10_10_to_12_16", 1'b0, 12, 16, 7, 5, -1, 0, -1);

    run_cmd("move_5_5", 1'b1, 5, 5, 0, -1, -1, 0, -1);
    push(5, 5); push(6, 5); push(7, 5); push(8, 5);
    run_cmd("stall_5_5_to_8_5", 1'b0, 8, 5, 4, 5, 1, 3, -1);

    run_cmd("move_20_20", 1'b1, 20, 20, 0, -1, -1, 0, -1);
    push(20, 20);
    run_cmd("point_20_20", 1'b0, 20, 20, 1, 5, -1, 0, -1);

    // Reset in the middle of a 10-pixel line.
    run_cmd("move_0_0", 1'b1, 0, 0, 0, -1, -1, 0, -1);
    for (int i = 0; i <= 9; i++) push(i, 0);
    base = xfers;
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_move  = 1'b0;
    bus.cmd_x     = 9'd9;
    bus.cmd_y     = 9'd0;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 50 && xfers < base + 3; c++) begin
      @(negedge clock); #1;
    end
    check("midline_plots_before_reset", xfers - base, 3);
    @(posedge clock); #2;
    resetN = 1'b0;
    #1;
    check("midline_rst_plot_valid", int'(bus.plot_valid), 0);
    check("midline_rst_busy", int'(bus.busy), 0);
    check("midline_rst_line_done", int'(bus.line_done), 0);
    check("midline_rst_old_enables", int'({bus.old_X_enable, bus.old_Y_enable}), 0);
    check("midline_rst_state_code", int'(bus.state), 1);
    exp_q.delete();
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i <= 2; i++) push(i, 0);
    run_cmd("after_reset_0_0_to_2_0", 1'b0, 2, 0, 3, 5, -1, 0, -1);

`ifdef LINE_DRAW_CTRL_ABORT_EN
    run_cmd("abort_move_0_0", 1'b1, 0, 0, 0, -1, -1, 0, -1);
    push(0, 0); push(1, 0);
    run_cmd("abort_0_0_to_9_0", 1'b0, 9, 0, 2, 5, -1, 0, 2);
    push(9, 0); push(10, 0);
    run_cmd("after_abort_9_0_to_10_0", 1'b0, 10, 0, 2, 5, -1, 0, -1);
`endif

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
